mse_accum: RTL and testbench

MSE_ACCUM -- requirements
Module: mse_accum

---
 rtl/mse_pkg.sv | 40 ++++
 rtl/sq_err_stage.sv | 57 +++++
 rtl/mse_accum.sv | 201 ++++++++++++++++++++
 tb/tb_mse_accum.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mse_pkg.sv
// Shared widths, FSM state type and small arithmetic helpers for the
// mean-squared-error accumulator (mse_accum) and its pipeline stage.
package mse_pkg;

  localparam int SAMPLE_W = 16;   // ref_x / dut_y
  localparam int ERR_W    = 17;   // ref_x - dut_y, never wraps
  localparam int SQ_W     = 34;   // d*d
  localparam int ACC_W    = 48;   // 2^15 squares of at most 65535^2 fit
  localparam int MSE_W    = 32;
  localparam int CNT_W    = 16;   // holds 2^15
  localparam int WL_W     = 4;
  localparam int DRAIN_W  = 2;

  // Cycles spent in DRAIN after the accepting edge: d and square are still
  // in flight, then one edge for the final accumulate to land.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sign-extend both samples by one bit so the difference cannot overflow.
  function automatic logic signed [ERR_W-1:0] sample_diff(
    input logic signed [SAMPLE_W-1:0] x,
    input logic signed [SAMPLE_W-1:0] y
  );
    return $signed({x[SAMPLE_W-1], x}) - $signed({y[SAMPLE_W-1], y});
  endfunction

  // |d| as unsigned; the most negative difference is -65535, so it fits.
  function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] d);
    logic signed [ERR_W-1:0] neg;
    neg = -d;
    return d[ERR_W-1] ? $unsigned(neg) : $unsigned(d);
  endfunction

endpackage

// File: rtl/sq_err_stage.sv
// Two-stage subtract/square pipeline feeding the mse_accum accumulator.
// Stage 1 registers d = ref - dut, stage 2 registers d*d. valid_o follows
// valid_i by two edges.
module sq_err_stage
  import mse_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       valid_i,
  input  logic signed [SAMPLE_W-1:0] ref_i,
  input  logic signed [SAMPLE_W-1:0] dut_i,
  output logic                       valid_o,
  output logic [SQ_W-1:0]            square_o
);

  logic                    d_vld_q;
  logic signed [ERR_W-1:0] d_q;
  logic                    sq_vld_q;
  logic [SQ_W-1:0]         sq_q;
  logic signed [SQ_W-1:0]  prod;

  // Widen both operands first; the true product is below 2^32 so the
  // 34-bit signed result is exact and non-negative.
  always_comb begin
    prod = SQ_W'(d_q) * SQ_W'(d_q);
  end

  // Stage 1: register the error.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      d_vld_q <= 1'b0;
      d_q     <= '0;
    end else begin
      d_vld_q <= valid_i;
      if (valid_i) begin
        d_q <= sample_diff(ref_i, dut_i);
      end
    end
  end

  // Stage 2: register the square.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sq_vld_q <= 1'b0;
      sq_q     <= '0;
    end else begin
      sq_vld_q <= d_vld_q;
      if (d_vld_q) begin
        sq_q <= $unsigned(prod);
      end
    end
  end

  assign valid_o  = sq_vld_q;
  assign square_o = sq_q;

endmodule

// File: rtl/mse_accum.sv
// Mean-squared-error accumulator: collects 2^win_log2 accepted sample pairs,
// sums (ref_x - dut_y)^2 and publishes sse / mse with a one-cycle done pulse.
// Optional feature macro: MSE_ACCUM_MAXERR_EN adds err_max (max |d| of the
// last completed window).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset, waiting for start
//   ST_RUN   | accepting samples on in_valid until the window is full
//   ST_DRAIN | last sample moving through subtract/square/accumulate
//   ST_DONE  | results published, waiting for the next start
module mse_accum
  import mse_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
  input  logic [WL_W-1:0]            win_log2,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] ref_x,
  input  logic signed [SAMPLE_W-1:0] dut_y,
  output logic                       busy,
  output logic                       done,
  output logic [ACC_W-1:0]           sse,
  output logic [MSE_W-1:0]           mse
`ifdef MSE_ACCUM_MAXERR_EN
  ,
  output logic [ERR_W-1:0]           err_max
`endif
);

  state_e               state_q, state_d;
  logic [WL_W-1:0]      wl_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     win_len;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     sse_q, sse_d;
  logic [MSE_W-1:0]     mse_q, mse_d;
  logic                 done_q, done_d;

  logic                 start_acc;
  logic                 accept;
  logic                 last_acc;
  logic                 drain_end;
  logic                 sq_vld;
  logic [SQ_W-1:0]      sq_val;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    accept    = (state_q == ST_RUN) && in_valid;
    cnt_inc   = cnt_q + CNT_W'(1);
    win_len   = CNT_W'(1) << wl_q;
    last_acc  = accept && (cnt_inc == win_len);
    drain_end = (state_q == ST_DRAIN) && (drain_q == '0);
  end

  // Subtract and square; accepted pairs only.
  sq_err_stage u_sq_err_stage (
    .clk      (clk),
    .rstN     (rstN),
    .valid_i  (accept),
    .ref_i    (ref_x),
    .dut_i    (dut_y),
    .valid_o  (sq_vld),
    .square_o (sq_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_RUN;
      ST_RUN:   if (last_acc)   state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end)  state_d = ST_DONE;
      ST_DONE:  if (start)      state_d = ST_RUN;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and result ports.
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done = done_q;
    sse  = sse_q;
    mse  = mse_q;
  end

  // Datapath next-state: sample counter, drain timer, accumulator, results.
  always_comb begin
    cnt_d   = cnt_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    sse_d   = sse_q;
    mse_d   = mse_q;
    done_d  = 1'b0;

    if (start_acc) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_inc;
    end

    if (last_acc) begin
      drain_d = DRAIN_LAST;
    end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
      drain_d = drain_q - DRAIN_W'(1);
    end

    // The pipeline is empty whenever a start can be accepted, so clearing
    // never collides with an arriving square.
    if (start_acc) begin
      acc_d = '0;
    end else if (sq_vld) begin
      acc_d = acc_q + ACC_W'(sq_val);
    end

    // By the end of DRAIN the final square has been folded into acc_q.
    if (drain_end) begin
      sse_d  = acc_q;
      mse_d  = MSE_W'(acc_q >> wl_q);
      done_d = 1'b1;
    end
  end

  // Datapath registers; window length is latched so mid-window changes on
  // win_log2 affect neither the count nor the mse shift.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wl_q    <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      acc_q   <= '0;
      sse_q   <= '0;
      mse_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        wl_q <= win_log2;
      end
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
      sse_q   <= sse_d;
      mse_q   <= mse_d;
      done_q  <= done_d;
    end
  end

`ifdef MSE_ACCUM_MAXERR_EN
  logic [ERR_W-1:0] emax_run_q;
  logic [ERR_W-1:0] emax_q;
  logic [ERR_W-1:0] cur_abs;

  // |d| of the pair being accepted this cycle.
  always_comb begin
    cur_abs = abs_err(sample_diff(ref_x, dut_y));
  end

  // Running max tracks accepts; the published value moves with done.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      emax_run_q <= '0;
      emax_q     <= '0;
    end else begin
      if (start_acc) begin
        emax_run_q <= '0;
        emax_q     <= '0;
      end else begin
        if (accept && (cur_abs > emax_run_q)) begin
          emax_run_q <= cur_abs;
        end
        if (drain_end) begin
          emax_q <= emax_run_q;
        end
      end
    end
  end

  assign err_max = emax_q;
`endif

  // done is a single-cycle pulse on entry to DONE.
  a_done_pulse : assert property (@(posedge clk) disable iff (!rstN) done |=> !done);

  // The sample counter never runs past the window while collecting.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rstN)
                                 (state_q == ST_RUN) |-> (cnt_q < win_len));

endmodule

// File: tb/tb_mse_accum.sv
module tb_mse_accum;

  logic               clk = 1'b0;
  logic               rstN = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         win_log2 = 4'd0;
  logic               in_valid = 1'b0;
  logic signed [15:0] ref_x = '0;
  logic signed [15:0] dut_y = '0;
  logic               busy;
  logic               done;
  logic [47:0]        sse;
  logic [31:0]        mse;
`ifdef MSE_ACCUM_MAXERR_EN
  logic [16:0]        err_max;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int q_x[$];
  int q_y[$];

  mse_accum dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
    .win_log2 (win_log2),
    .in_valid (in_valid),
    .ref_x    (ref_x),
    .dut_y    (dut_y),
    .busy     (busy),
    .done     (done),
    .sse      (sse),
    .mse      (mse)
`ifdef MSE_ACCUM_MAXERR_EN
    ,
    .err_max  (err_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic start_window(input int wl, input string name);
    win_log2 = 4'(wl);
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_run"}, 64'(busy), 64'd1);
  endtask

  task automatic feed(input int x, input int y);
    start    = 1'b0;
    in_valid = 1'b1;
    ref_x    = 16'(x);
    dut_y    = 16'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Idle cycles carrying garbage data; when noisy, also toggle start and
  // win_log2, both of which must be ignored while collecting.
  task automatic idle_cycles(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      ref_x    = 16'($urandom);
      dut_y    = 16'($urandom);
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        win_log2 = 4'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
  endtask

  // One complete window against the reference sums; pairs come from the
  // queues when filled, otherwise random.
  task automatic run_window(input int wl, input bit gaps, input string name);
    longint s;
    int     emax;
    int     n;
    int     x, y, d, ad, edges;
    s    = 0;
    emax = 0;
    n    = 1 << wl;
    start_window(wl, name);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle_cycles($urandom_range(0, 2), 1'b1);
      if (q_x.size() > 0) begin
        x = q_x.pop_front();
        y = q_y.pop_front();
      end else begin
        x = rand_s16();
        y = rand_s16();
      end
      d  = x - y;
      ad = (d < 0) ? -d : d;
      s += longint'(d) * longint'(d);
      if (ad > emax) emax = ad;
      feed(x, y);
    end
    chk({name, "_busy_drain"}, 64'(busy), 64'd1);
    chk({name, "_done_early"}, 64'(done), 64'd0);
    wait_done(edges);
    chk({name, "_latency"}, 64'(edges), 64'd3);
    chk({name, "_sse"}, 64'(sse), 64'(s));
    chk({name, "_mse"}, 64'(mse), 64'((s >> wl) & 64'hFFFF_FFFF));
`ifdef MSE_ACCUM_MAXERR_EN
    chk({name, "_err_max"}, 64'(err_max), 64'(emax));
`endif
    @(posedge clk); #1;
    chk({name, "_done_drop"}, 64'(done), 64'd0);
    chk({name, "_sse_hold"}, 64'(sse), 64'(s));
    chk({name, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int v;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sse", 64'(sse), 64'd0);
    chk("rst_mse", 64'(mse), 64'd0);
    rstN = 1'b1;
    idle_cycles(2, 1'b0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Identical samples, 8-sample window.
    for (int i = 0; i < 8; i++) begin
      v = rand_s16();
      q_x.push_back(v);
      q_y.push_back(v);
    end
    run_window(3, 1'b0, "zero_err");

    // Constant error of 2 over 4 samples.
    for (int i = 0; i < 4; i++) begin
      q_x.push_back(100);
      q_y.push_back(98);
    end
    run_window(2, 1'b0, "const2");

    // Extreme single-sample window.
    q_x.push_back(32767);
    q_y.push_back(-32768);
    run_window(0, 1'b0, "extreme1");

    // Gapped window with start pulsed in RUN and a late sample in DONE.
    start_window(1, "gap");
    feed(10, 7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(1, 1'b0);
    feed(-2, 3);
    wait_done(edges);
    chk("gap_latency", 64'(edges), 64'd3);
    chk("gap_sse", 64'(sse), 64'd34);
    chk("gap_mse", 64'(mse), 64'd17);
    feed(1000, -1000);
    chk("gap_late_done", 64'(done), 64'd0);
    chk("gap_late_sse", 64'(sse), 64'd34);
    chk("gap_late_busy", 64'(busy), 64'd0);

    // Reset in the middle of a 16-sample window.
    start_window(4, "midrst");
    for (int i = 0; i < 5; i++) feed(rand_s16(), rand_s16());
    #3;
    rstN = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sse", 64'(sse), 64'd0);
    chk("midrst_mse", 64'(mse), 64'd0);
`ifdef MSE_ACCUM_MAXERR_EN
    chk("midrst_err_max", 64'(err_max), 64'd0);
`endif
    @(posedge clk); #1;
    rstN = 1'b1;
    idle_cycles(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = rand_s16() % 30000;
      q_x.push_back(v + 1);
      q_y.push_back(v);
    end
    run_window(2, 1'b0, "post_rst");

    // Max-error window: errors 2, -9, 4, 0.
    q_x.push_back(12);  q_y.push_back(10);
    q_x.push_back(-5);  q_y.push_back(4);
    q_x.push_back(4);   q_y.push_back(0);
    q_x.push_back(-77); q_y.push_back(-77);
    run_window(2, 1'b0, "maxerr");

    // Random windows with gaps, ignored starts and win_log2 changes.
    for (int k = 0; k < 8; k++) begin
      run_window(int'($urandom_range(0, 6)), 1'b1, $sformatf("rand%0d", k));
    end

    // Longest window with worst-case error on every sample.
    for (int i = 0; i < 32768; i++) begin
      q_x.push_back(32767);
      q_y.push_back(-32768);
    end
    run_window(15, 1'b0, "full_scale");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
